wrr_stream_arbiter: RTL
=======================

Name: wrr_stream_arbiter

Overview:
- Weighted round-robin arbiter sharing one valid/ready output stream among NumInp requesting streams.
- Each grant is held for a burst of up to weight[i] transfers, then rotates to the next requester.
- Sits in front of shared stream resources (delay lines, demuxes, CDC FIFOs) where plain per-beat round-robin gives poor burst locality.
- Output handshake is stable: once the output is valid, the selection never changes before the transfer completes.

Parameters:
- NumInp, 4: number of input streams, ≥2.
- DataWidth, 32: payload width.
- WeightWidth, 4: width of each per-input burst weight.
- IdxWidth, $clog2(NumInp): derived; do not override.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- weight_i  in  NumInp*WeightWidth  burst weight per input; slice i = input i; 0 treated as 1
- inp_data_i  in  NumInp*DataWidth  input payloads, slice i = input i
- inp_valid_i  in  NumInp  input valids
- inp_ready_o  out  NumInp  input readies
- oup_data_o  out  DataWidth  selected payload
- oup_idx_o  out  IdxWidth  index of the selected input
- oup_valid_o  out  1  output valid
- oup_ready_i  in  1  output ready

Behaviour:
- One clock; reset is synchronous and active-high (clk_i, rst_i).
- While rst_i=1:
  - inp_ready_o=0, oup_valid_o=0, oup_idx_o=0, oup_data_o=0.
  - Next state is IDLE, rr_ptr=0, cnt=0.
- Handshake = oup_valid_o & oup_ready_i.
- inp_ready_o[sel] = oup_ready_i while oup_valid_o=1; all other inp_ready_o bits are 0.
- Datapath is combinational from the selected input to the output: zero latency, no buffering.
- Effective weight w_eff = max(weight_i[sel], 1), sampled only when a grant is taken in IDLE.
- IDLE state:
  - sel = first i with inp_valid_i[i]=1, searching cyclically from rr_ptr.
  - oup_valid_o = |inp_valid_i.
  - No valid input: stay in IDLE.
  - Handshake and w_eff=1: stay in IDLE, rr_ptr ← (sel+1) mod NumInp.
  - Handshake and w_eff>1: go to GRANT, gidx ← sel, cnt ← w_eff-1.
  - Valid but no handshake (stall): go to GRANT, gidx ← sel, cnt ← w_eff. This locks the selection.
- GRANT state:
  - sel = gidx; oup_valid_o = inp_valid_i[gidx].
  - On each handshake, cnt ← cnt-1.
  - cnt reaches 0 on a handshake: go to IDLE, rr_ptr ← (gidx+1) mod NumInp.
  - inp_valid_i[gidx]=0 (requester finished its burst early): go to IDLE next cycle, rr_ptr ← (gidx+1) mod NumInp. No output valid is presented that cycle.
- Wrap-around: rr_ptr wraps from NumInp-1 to 0. Maximum weight 2^WeightWidth-1 gives exactly that many beats.
- Changing weight_i during a GRANT has no effect until the next IDLE selection.
- Synchronous reset mid-burst aborts the grant. The transfer in flight that cycle is not accepted (ready forced to 0).
- Inputs must obey the stream rule: valid never drops before its handshake. If violated, the arbiter still releases the grant as above.
- Fairness: every continuously valid input is granted within NumInp-1 other bursts.

Optional Feature:
- Macro: WRR_ARB_PRIO_EN. Makes input 0 a priority requester.
- When defined:
  - In IDLE, input 0 wins whenever inp_valid_i[0]=1, regardless of rr_ptr.
  - In GRANT of gidx≠0, if inp_valid_i[0]=1 at a handshake, the burst ends after that handshake (cnt forced to 0). rr_ptr ← gidx+1 as normal.
  - Grants to input 0 never modify rr_ptr.
- When undefined: input 0 is an ordinary round-robin requester, and no extra logic is generated.

Test Plan:
- Reset and idle: hold rst_i for 2 cycles with all inputs valid.
  - Required: oup_valid_o=0 and inp_ready_o=0 throughout.
  - First grant after release goes to idx 0.
- Weighted rotation: weights {3,1,2,1}, all inputs continuously valid, oup_ready_i=1.
  - Required index sequence: 0,0,0,1,2,2,3,0,0,0,…
- Backpressure lock: only input 2 valid (data 0xA5); oup_ready_i=0 for 5 cycles; then raise input 1 valid.
  - Required: oup_idx_o stays 2 and oup_data_o stays 0xA5 until the handshake.
- Early release and weight 0: weights all 4, input 1 sends 2 beats then drops valid; input 3 is valid with weight 0.
  - Required: grant moves to input 3 after a 1-cycle gap.
  - Input 3 receives exactly 1 beat.
- Reset mid-burst: assert rst_i during beat 2 of a weight-5 burst from input 2.
  - Required: no handshake in the reset cycle.
  - After reset, arbitration restarts from idx 0.
- With WRR_ARB_PRIO_EN: weights all 4; input 1 is bursting when input 0 raises valid at beat 2.
  - Required: input 1 is granted 2 beats, then input 0 is granted.
  - After input 0, the next grant goes to input 2.

Source files
------------

// File: rtl/wrr_stream_arbiter_if.sv
// Stream bundle for wrr_stream_arbiter.
//   weight_i    : per-input burst weight, slice i = input i (0 behaves as 1)
//   inp_data_i  : per-input payloads, slice i = input i
//   inp_valid_i : per-input valids
//   inp_ready_o : per-input readies (only the selected input may see ready)
//   oup_data_o  : selected payload
//   oup_idx_o   : index of the selected input
//   oup_valid_o : output valid
//   oup_ready_i : output ready
// Modports: slave = arbiter side, master = requesters/consumer side.
interface wrr_stream_arbiter_if #(
  parameter int NumInp      = 4,
  parameter int DataWidth   = 32,
  parameter int WeightWidth = 4,
  parameter int IdxWidth    = $clog2(NumInp)
);
  logic [NumInp*WeightWidth-1:0] weight_i;
  logic [NumInp*DataWidth-1:0]   inp_data_i;
  logic [NumInp-1:0]             inp_valid_i;
  logic [NumInp-1:0]             inp_ready_o;
  logic [DataWidth-1:0]          oup_data_o;
  logic [IdxWidth-1:0]           oup_idx_o;
  logic                          oup_valid_o;
  logic                          oup_ready_i;

  modport slave (
    input  weight_i, inp_data_i, inp_valid_i, oup_ready_i,
    output inp_ready_o, oup_data_o, oup_idx_o, oup_valid_o
  );

  modport master (
    output weight_i, inp_data_i, inp_valid_i, oup_ready_i,
    input  inp_ready_o, oup_data_o, oup_idx_o, oup_valid_o
  );
endinterface

// File: rtl/wrr_stream_arbiter.sv
// Weighted round-robin arbiter: NumInp valid/ready streams share one output.
// A granted input keeps the output for up to max(weight,1) beats, then the
// round-robin pointer moves past it. Datapath is combinational (no buffering).
// Once the output is valid the selection is locked until it transfers.
// Ports:
//   clk_i : clock
//   rst_i : synchronous active-high reset (forces all outputs to 0)
//   bus   : wrr_stream_arbiter_if.slave (weights, input streams, output stream)
// Optional build macro WRR_ARB_PRIO_EN: input 0 becomes a priority requester
// (wins every IDLE selection, cuts other bursts short, never moves rr_ptr).

// Per-input helper: effective weight and ready steering.
module wrr_stream_arbiter_lane #(
  parameter int IdxWidth    = 2,
  parameter int WeightWidth = 4,
  parameter int Lane        = 0
) (
  input  logic [WeightWidth-1:0] weight_i,
  input  logic [IdxWidth-1:0]    sel_i,
  input  logic                   xfer_en_i,
  output logic [WeightWidth-1:0] w_eff_o,
  output logic                   ready_o
);
  assign w_eff_o = (weight_i == '0) ? WeightWidth'(1) : weight_i;
  assign ready_o = xfer_en_i && (sel_i == IdxWidth'(Lane));
endmodule

module wrr_stream_arbiter #(
  parameter int NumInp      = 4,
  parameter int DataWidth   = 32,
  parameter int WeightWidth = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  wrr_stream_arbiter_if.slave  bus
);
  localparam int IdxWidth = $clog2(NumInp);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e                 state_q;
  logic [IdxWidth-1:0]    rr_ptr_q;
  logic [IdxWidth-1:0]    gidx_q;
  logic [WeightWidth-1:0] cnt_q;

  logic [NumInp-1:0][DataWidth-1:0]   data_arr;
  logic [NumInp-1:0][WeightWidth-1:0] w_eff;
  logic [NumInp-1:0]                  lane_ready;

  logic [IdxWidth-1:0]    sel_rr, idle_sel, sel;
  logic                   rr_hit, any_valid, oup_valid, xfer, preempt;
  logic [WeightWidth-1:0] idle_w;
  logic [IdxWidth-1:0]    rr_after_idle, rr_after_grant;

  assign data_arr = bus.inp_data_i;

  function automatic logic [IdxWidth-1:0] next_idx(input logic [IdxWidth-1:0] i);
    return (i == IdxWidth'(NumInp-1)) ? '0 : i + IdxWidth'(1);
  endfunction

  // Cyclic first-valid search starting at rr_ptr.
  always_comb begin
    int                  j;
    logic [IdxWidth-1:0] jidx;
    sel_rr = rr_ptr_q;
    rr_hit = 1'b0;
    j      = 0;
    jidx   = '0;
    for (int k = 0; k < NumInp; k++) begin
      j = int'(rr_ptr_q) + k;
      if (j >= NumInp) j = j - NumInp;
      jidx = IdxWidth'(j);
      if (!rr_hit && bus.inp_valid_i[jidx]) begin
        rr_hit = 1'b1;
        sel_rr = jidx;
      end
    end
  end

`ifdef WRR_ARB_PRIO_EN
  assign idle_sel       = bus.inp_valid_i[0] ? '0 : sel_rr;
  // Input 0 may cut another requester's burst short at any handshake.
  assign preempt        = (gidx_q != '0) && bus.inp_valid_i[0];
  // Priority grants leave the round-robin order untouched.
  assign rr_after_idle  = (idle_sel == '0) ? rr_ptr_q : next_idx(idle_sel);
  assign rr_after_grant = (gidx_q == '0) ? rr_ptr_q : next_idx(gidx_q);
`else
  assign idle_sel       = sel_rr;
  assign preempt        = 1'b0;
  assign rr_after_idle  = next_idx(idle_sel);
  assign rr_after_grant = next_idx(gidx_q);
`endif

  assign any_valid = |bus.inp_valid_i;
  assign sel       = (state_q == GRANT) ? gidx_q : idle_sel;
  assign idle_w    = w_eff[idle_sel];

  // Reset masks the output so nothing transfers in a reset cycle.
  assign oup_valid = !rst_i && ((state_q == GRANT) ? bus.inp_valid_i[gidx_q] : any_valid);
  assign xfer      = oup_valid && bus.oup_ready_i;

  for (genvar g = 0; g < NumInp; g++) begin : g_lane
    wrr_stream_arbiter_lane #(
      .IdxWidth    (IdxWidth),
      .WeightWidth (WeightWidth),
      .Lane        (g)
    ) u_lane (
      .weight_i  (bus.weight_i[g*WeightWidth +: WeightWidth]),
      .sel_i     (sel),
      .xfer_en_i (xfer),
      .w_eff_o   (w_eff[g]),
      .ready_o   (lane_ready[g])
    );
  end

  assign bus.inp_ready_o = lane_ready;
  assign bus.oup_valid_o = oup_valid;
  assign bus.oup_idx_o   = rst_i ? '0 : sel;
  assign bus.oup_data_o  = rst_i ? '0 : data_arr[sel];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      gidx_q   <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_valid) begin
            if (xfer) begin
              if (idle_w == WeightWidth'(1)) begin
                rr_ptr_q <= rr_after_idle;
              end else begin
                state_q <= GRANT;
                gidx_q  <= idle_sel;
                cnt_q   <= idle_w - WeightWidth'(1);
              end
            end else begin
              // Stall: lock the selection with the full burst still owed.
              state_q <= GRANT;
              gidx_q  <= idle_sel;
              cnt_q   <= idle_w;
            end
          end
        end
        GRANT: begin
          if (!bus.inp_valid_i[gidx_q]) begin
            state_q  <= IDLE;
            rr_ptr_q <= rr_after_grant;
          end else if (xfer) begin
            if (cnt_q == WeightWidth'(1) || preempt) begin
              state_q  <= IDLE;
              rr_ptr_q <= rr_after_grant;
              cnt_q    <= '0;
            end else begin
              cnt_q <= cnt_q - WeightWidth'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
